// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, oversample rate and prescale helper.
package uart_pkg;

  localparam int unsigned OversampleRate = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Prescale value for a given clock and baud rate (clocks per oversample tick).
  function automatic int unsigned prescale_f(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / (baud * OversampleRate);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: prescale counter feeding a 3-bit oversample counter; bit_done_o marks
// the last clock of each 8*Prescale-clock bit. Shared by the UART transmitter and receiver.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter logic [15:0] Prescale = 16'd27
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  output logic bit_done_o
);

  // A prescale of zero behaves like one.
  localparam logic [15:0] PrescMax = (Prescale == 16'd0) ? 16'd0 : Prescale - 16'd1;
  localparam logic [2:0]  OsMax    = 3'(OversampleRate - 1);

  logic [15:0] presc_cnt_q;
  logic [2:0]  os_cnt_q;
  logic        tick;

  assign tick       = (presc_cnt_q == PrescMax);
  assign bit_done_o = tick && (os_cnt_q == OsMax);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      presc_cnt_q <= 16'd0;
      os_cnt_q    <= 3'd0;
    end else if (clear_i) begin
      presc_cnt_q <= 16'd0;
      os_cnt_q    <= 3'd0;
    end else if (tick) begin
      presc_cnt_q <= 16'd0;
      os_cnt_q    <= os_cnt_q + 3'd1;
    end else begin
      presc_cnt_q <= presc_cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: ready/valid byte in, start + DataWidth bits LSB first + StopBits stop bits out.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter logic [15:0] Prescale  = 16'd27,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned StopBits  = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int unsigned         BitCntW  = $clog2(DataWidth + 1);
  localparam logic [BitCntW-1:0]  LastData = BitCntW'(DataWidth - 1);
  localparam logic [BitCntW-1:0]  LastStop = BitCntW'(StopBits - 1);

  tx_state_e            state_q, state_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 handshake;
  logic                 bit_done;
  logic                 cnt_clear;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign handshake = valid_i && ready_q;
  // Restart bit timing on every state change so each bit is exactly 8*Prescale clocks.
  assign cnt_clear = (state_q == IDLE) || (state_d != state_q);

  uart_baud_tick #(
    .Prescale(Prescale)
  ) u_baud_tick (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .clear_i   (cnt_clear),
    .bit_done_o(bit_done)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (handshake) state_d = START;
      START: if (bit_done) state_d = DATA;
      DATA: begin
        if (bit_done && (bit_cnt_q == LastData)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) state_d = STOP;
`endif
      STOP:  if (bit_done && (bit_cnt_q == LastStop)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so tx_o/ready_o/busy_o flops line up with state_q.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = 1'b1;
    ready_d   = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    if (handshake) begin
      shift_d  = data_i;
`ifdef UART_TX_PARITY_EN
      parity_d = ^data_i;
`endif
    end else if ((state_q == DATA) && bit_done) begin
      shift_d = shift_q >> 1;
    end

    if (state_d != state_q) begin
      bit_cnt_d = '0;
    end else if (bit_done) begin
      bit_cnt_d = bit_cnt_q + BitCntW'(1);
    end

    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_o    = tx_q;
  assign ready_o = ready_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two configurations (Prescale=2/1 stop, Prescale=0/2 stop) checked cycle by
// cycle against a line-waveform model built from the frame format.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data  [2];
  logic          valid [2];
  logic          ready [2];
  logic          tx    [2];
  logic          busy  [2];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  uart_tx #(.Prescale(16'd2), .DataWidth(DW), .StopBits(1)) dut0 (
    .clk_i(clk), .reset_ni(rst_n), .data_i(data[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0])
  );

  uart_tx #(.Prescale(16'd0), .DataWidth(DW), .StopBits(2)) dut1 (
    .clk_i(clk), .reset_ni(rst_n), .data_i(data[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1])
  );

  // Reference model: clocks per bit, bits per frame, and the level of frame bit idx.
  function automatic int bit_period(input int i);
    return (i == 0) ? 16 : 8;
  endfunction

  function automatic int frame_bits(input int i);
    return 1 + DW + ((i == 0) ? 1 : 2) + PAR;
  endfunction

  function automatic logic line_bit(input logic [DW-1:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return b[idx-1];
    if ((PAR == 1) && (idx == DW + 1)) return ^b;
    return 1'b1;
  endfunction

  // Called right after a handshake edge: follows the whole frame plus the first idle cycle.
  task automatic expect_frame(input int i, input logic [DW-1:0] b);
    int nb = frame_bits(i);
    int bp = bit_period(i);
    logic [2:0] got, exp;
    for (int k = 0; k < nb * bp; k++) begin
      @(negedge clk);
      exp = {line_bit(b, k / bp), 1'b1, 1'b0};
      got = {tx[i], busy[i], ready[i]};
      checks++;
      if (got !== exp)
        $display("FAIL frame%0d byte=%02h cycle T+%0d: {tx,busy,ready}=%b expected %b",
                 i, b, k + 1, got, exp);
      else passes++;
    end
    @(negedge clk);
    got = {tx[i], busy[i], ready[i]};
    checks++;
    if (got !== 3'b101)
      $display("FAIL idle_after%0d byte=%02h: {tx,busy,ready}=%b expected 101", i, b, got);
    else passes++;
  endtask

  // Waits (bounded) for ready, presents the byte and returns just after the handshake edge.
  task automatic start_frame(input int i, input logic [DW-1:0] b);
    int n = 0;
    @(negedge clk);
    while ((ready[i] !== 1'b1) && (n < 5000)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready[i] !== 1'b1) $display("FAIL ready_timeout%0d: ready=%b expected 1", i, ready[i]);
    else passes++;
    data[i]  = b;
    valid[i] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] got;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0;
      data[i]  = DW'($urandom);
    end
    #23;
    for (int i = 0; i < 2; i++) begin
      got = {tx[i], busy[i], ready[i]};
      checks++;
      if (got !== 3'b101) $display("FAIL reset%0d: {tx,busy,ready}=%b expected 101", i, got);
      else passes++;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      got = {tx[i], busy[i], ready[i]};
      checks++;
      if (got !== 3'b101) $display("FAIL post_reset%0d: {tx,busy,ready}=%b expected 101", i, got);
      else passes++;
    end
  endtask

  task automatic test_patterns();
    logic [DW-1:0] pats [6];
    pats[0] = 8'h55; pats[1] = 8'h07; pats[2] = 8'h03;
    pats[3] = 8'h00; pats[4] = 8'hFF; pats[5] = DW'($urandom);
    for (int p = 0; p < 6; p++) begin
      start_frame(0, pats[p]);
      valid[0] = 1'b0;
      data[0]  = DW'($urandom);
      expect_frame(0, pats[p]);
    end
    start_frame(1, 8'hFF);
    valid[1] = 1'b0;
    data[1]  = DW'($urandom);
    expect_frame(1, 8'hFF);
  endtask

  task automatic test_back_to_back();
    start_frame(0, 8'hA3);
    data[0] = 8'h0F;
    expect_frame(0, 8'hA3);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    data[0]  = DW'($urandom);
    expect_frame(0, 8'h0F);
  endtask

  task automatic test_valid_while_busy();
    logic [DW-1:0] b = DW'($urandom);
    int bad = 0;
    start_frame(0, b);
    valid[0] = 1'b0;
    fork
      expect_frame(0, b);
      begin
        repeat (30) @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = DW'($urandom);
        repeat (20) @(negedge clk);
        valid[0] = 1'b0;
      end
    join
    repeat (40) begin
      @(negedge clk);
      if ({tx[0], busy[0], ready[0]} !== 3'b101) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL dropped_valid: %0d non-idle cycles, expected 0", bad);
    else passes++;
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] got;
    start_frame(0, 8'h00);
    valid[0] = 1'b0;
    repeat (bit_period(0) * 4 + bit_period(0) / 2) @(negedge clk);
    checks++;
    if (tx[0] !== 1'b0) $display("FAIL mid_frame_bit3: tx=%b expected 0", tx[0]);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    got = {tx[0], busy[0], ready[0]};
    checks++;
    if (got !== 3'b101) $display("FAIL async_reset: {tx,busy,ready}=%b expected 101", got);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    got = {tx[0], busy[0], ready[0]};
    checks++;
    if (got !== 3'b101) $display("FAIL reset_release: {tx,busy,ready}=%b expected 101", got);
    else passes++;
    start_frame(0, 8'h81);
    valid[0] = 1'b0;
    expect_frame(0, 8'h81);
  endtask

  task automatic test_random();
    logic [DW-1:0] b;
    for (int n = 0; n < 16; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      b = DW'($urandom);
      start_frame(0, b);
      valid[0] = 1'b0;
      data[0]  = DW'($urandom);
      expect_frame(0, b);
    end
  endtask

  task automatic test_loopback();
    start_frame(1, 8'h00);
    for (int b = 0; b < 256; b++) begin
      if (b < 255) data[1] = DW'(b + 1);
      else valid[1] = 1'b0;
      expect_frame(1, DW'(b));
      if (b < 255) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_back_to_back();
    test_valid_while_busy();
    test_reset_mid_frame();
    test_random();
    test_loopback();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
